// File: rtl/reg_bank_8x16.sv
// rtl/reg_bank_8x16.sv - eight-entry register bank with a per-register busy scoreboard
//
// Purpose:
//   Holds eight WIDTH-bit architectural registers that are all driven out in parallel.
//   Each register also has a busy bit. The issue stage sets a register's busy bit when it
//   reserves that register as a destination, and a writeback clears the bit again. A
//   reservation that is refused, or a writeback to a register that is not busy, sets a
//   sticky error flag.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   wr_en     in   writeback strobe
//   wr_addr   in   [2:0] writeback destination index
//   wr_data   in   [WIDTH-1:0] writeback data
//   rsv_en    in   reserve-destination request
//   rsv_addr  in   [2:0] register to reserve
//   rsv_ok    out  combinational; a reservation of rsv_addr would be accepted this cycle
//   busy      out  [7:0] pending-write scoreboard
//   err       out  sticky error flag
//   q0..q7    out  [WIDTH-1:0] register contents, feeding read mux inputs in0..in7

module reg_bank_8x16 #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               BYPASS    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rsv_en,
    input  logic [2:0]       rsv_addr,
    output logic             rsv_ok,
    output logic [7:0]       busy,
    output logic             err,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7
);

    logic [WIDTH-1:0] regs  [8];
    logic [WIDTH-1:0] q_vis [8];
    logic [7:0]       busy_next;
    logic             err_next;
    logic             wr_hit_rsv;
    logic             rsv_take;
    logic             rsv_reject;
    logic             wr_unexpected;

    // A writeback to the register being reserved frees it in the same cycle, so the
    // reservation can be granted even though the busy bit is still set.
    assign wr_hit_rsv = wr_en && (wr_addr == rsv_addr);
    assign rsv_ok     = !rst && (!busy[rsv_addr] || wr_hit_rsv);

    assign rsv_take      = rsv_en && rsv_ok;
    assign rsv_reject    = rsv_en && !rsv_ok && !rst;
    assign wr_unexpected = wr_en && !busy[wr_addr];

    // The writeback clear comes first and the reservation set second, so a new
    // reservation of the register just written keeps its busy bit set.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (rsv_take) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    assign err_next = err || rsv_reject || wr_unexpected;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= RESET_VAL;
            end
            busy <= 8'h00;
            err  <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            busy <= busy_next;
            err  <= err_next;
        end
    end

    // The bypass depends only on the write port. The reservation inputs never reach
    // the data outputs.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if ((BYPASS != 0) && wr_en && (wr_addr == 3'(i))) begin
                q_vis[i] = wr_data;
            end else begin
                q_vis[i] = regs[i];
            end
        end
    end

    assign q0 = q_vis[0];
    assign q1 = q_vis[1];
    assign q2 = q_vis[2];
    assign q3 = q_vis[3];
    assign q4 = q_vis[4];
    assign q5 = q_vis[5];
    assign q6 = q_vis[6];
    assign q7 = q_vis[7];

endmodule

// File: tb/tb_reg_bank_8x16.sv
// tb/tb_reg_bank_8x16.sv - self-checking bench for reg_bank_8x16, registered and bypass variants

module tb_reg_bank_8x16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [2:0]  rsv_addr;

    logic        ok_a, ok_b, err_a, err_b;
    logic [7:0]  busy_a, busy_b;
    logic [15:0] qa [8];
    logic [15:0] qb [8];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: register values, set of pending registers, and the sticky flag.
    logic [15:0] m_reg  [8];
    bit          m_busy [8];
    bit          m_err;

    always #5 clk = ~clk;

    reg_bank_8x16 #(.WIDTH(16), .RESET_VAL(16'h0000), .BYPASS(0)) u_dut_reg (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(ok_a), .busy(busy_a), .err(err_a),
        .q0(qa[0]), .q1(qa[1]), .q2(qa[2]), .q3(qa[3]),
        .q4(qa[4]), .q5(qa[5]), .q6(qa[6]), .q7(qa[7])
    );

    reg_bank_8x16 #(.WIDTH(16), .RESET_VAL(16'h0000), .BYPASS(1)) u_dut_byp (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(ok_b), .busy(busy_b), .err(err_b),
        .q0(qb[0]), .q1(qb[1]), .q2(qb[2]), .q3(qb[3]),
        .q4(qb[4]), .q5(qb[5]), .q6(qb[6]), .q7(qb[7])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_busy_vec();
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) if (m_busy[i]) v = v | (8'h01 << i);
        return v;
    endfunction

    // Downstream 3-bit-select read mux fed by q0..q7 of the registered instance.
    function automatic logic [15:0] read_mux(input logic [2:0] sel);
        case (sel)
            3'd0: return qa[0];
            3'd1: return qa[1];
            3'd2: return qa[2];
            3'd3: return qa[3];
            3'd4: return qa[4];
            3'd5: return qa[5];
            3'd6: return qa[6];
            default: return qa[7];
        endcase
    endfunction

    // One clock: apply inputs, check combinational outputs mid-cycle, advance the model on
    // the edge, then check registered outputs just after the edge.
    task automatic run_cycle(input bit r, input bit we, input logic [2:0] wa, input logic [15:0] wd,
                             input bit re, input logic [2:0] ra);
        bit exp_ok;
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = ra;
        exp_ok = !r && (!m_busy[ra] || (we && wa == ra));
        @(negedge clk);
        check("rsv_ok_reg", 32'(ok_a), 32'(exp_ok));
        check("rsv_ok_byp", 32'(ok_b), 32'(exp_ok));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("q%0d_pre_reg", i), 32'(qa[i]), 32'(m_reg[i]));
            check($sformatf("q%0d_pre_byp", i), 32'(qb[i]),
                  32'((we && wa == 3'(i)) ? wd : m_reg[i]));
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[i]  = 16'h0000;
                m_busy[i] = 0;
            end
            m_err = 0;
        end else begin
            if (we) begin
                if (!m_busy[wa]) m_err = 1;
                m_reg[wa]  = wd;
                m_busy[wa] = 0;
            end
            if (re) begin
                if (exp_ok) m_busy[ra] = 1;
                else        m_err = 1;
            end
        end
        #1;
        check("busy_reg", 32'(busy_a), 32'(model_busy_vec()));
        check("busy_byp", 32'(busy_b), 32'(model_busy_vec()));
        check("err_reg", 32'(err_a), 32'(m_err));
        check("err_byp", 32'(err_b), 32'(m_err));
    endtask

    task automatic idle();
        run_cycle(0, 0, 3'd0, 16'h0, 0, 3'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_reg[i]  = 16'hxxxx;
            m_busy[i] = 0;
        end
        m_err = 0;

        // Reset with write and reserve asserted: reset must win, rsv_ok low throughout.
        rst = 1; wr_en = 1; wr_addr = 3'd3; wr_data = 16'hFFFF; rsv_en = 1; rsv_addr = 3'd3;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        run_cycle(1, 1, 3'd3, 16'hFFFF, 1, 3'd3);
        run_cycle(1, 1, 3'd3, 16'hFFFF, 1, 3'd3);
        idle();
        check("reset_busy", 32'(busy_a), 32'h00);
        check("reset_err", 32'(err_a), 32'h0);
        check("reset_q3", 32'(qa[3]), 32'h0000);

        // Reserve then write back register 5.
        run_cycle(0, 0, 3'd0, 16'h0, 1, 3'd5);
        check("rsv5_busy", 32'(busy_a), 32'h20);
        rst = 0; wr_en = 1; wr_addr = 3'd5; wr_data = 16'hBEEF; rsv_en = 0;
        #2;
        check("byp_q5_same_cycle", 32'(qb[5]), 32'hBEEF);
        run_cycle(0, 1, 3'd5, 16'hBEEF, 0, 3'd0);
        check("wb5_q5", 32'(qa[5]), 32'hBEEF);
        check("wb5_busy", 32'(busy_a), 32'h00);
        check("wb5_err", 32'(err_a), 32'h0);

        // Hazard: reserve 2 then request 2 again.
        run_cycle(0, 0, 3'd0, 16'h0, 1, 3'd2);
        run_cycle(0, 0, 3'd0, 16'h0, 1, 3'd2);
        check("hazard_err", 32'(err_a), 32'h1);
        check("hazard_busy", 32'(busy_a), 32'h04);

        // Fresh reset, hold reservation with no writeback: err on first rejected edge.
        run_cycle(1, 0, 3'd0, 16'h0, 0, 3'd0);
        run_cycle(0, 0, 3'd0, 16'h0, 1, 3'd6);
        check("hold_first_err", 32'(err_a), 32'h0);
        run_cycle(0, 0, 3'd0, 16'h0, 1, 3'd6);
        check("hold_reject_err", 32'(err_a), 32'h1);
        run_cycle(0, 0, 3'd0, 16'h0, 1, 3'd6);

        // Same-cycle release and re-reserve of register 7.
        run_cycle(1, 0, 3'd0, 16'h0, 0, 3'd0);
        run_cycle(0, 0, 3'd0, 16'h0, 1, 3'd7);
        run_cycle(0, 1, 3'd7, 16'h1234, 1, 3'd7);
        check("rerev_q7", 32'(qa[7]), 32'h1234);
        check("rerev_busy", 32'(busy_a), 32'h80);
        check("rerev_err", 32'(err_a), 32'h0);

        // Unexpected writeback; err sticky through 10 clean cycles, cleared only by reset.
        run_cycle(1, 0, 3'd0, 16'h0, 0, 3'd0);
        run_cycle(0, 1, 3'd0, 16'h00A5, 0, 3'd0);
        check("unexp_q0", 32'(qa[0]), 32'h00A5);
        check("unexp_err", 32'(err_a), 32'h1);
        for (int i = 0; i < 10; i++) idle();
        check("unexp_sticky", 32'(err_a), 32'h1);
        run_cycle(1, 0, 3'd0, 16'h0, 0, 3'd0);
        check("unexp_cleared", 32'(err_a), 32'h0);

        // Parallel independence: reg 4 reserved, then reserve 1 while writing 4.
        run_cycle(0, 0, 3'd0, 16'h0, 1, 3'd4);
        run_cycle(0, 1, 3'd4, 16'h5555, 1, 3'd1);
        check("par_busy", 32'(busy_a), 32'h02);
        check("par_q4", 32'(qa[4]), 32'h5555);
        check("par_err", 32'(err_a), 32'h0);

        // Sweep all addresses with distinct data, read back through the mux.
        run_cycle(1, 0, 3'd0, 16'h0, 0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            run_cycle(0, 0, 3'd0, 16'h0, 1, 3'(i));
            run_cycle(0, 1, 3'(i), 16'hA000 + 16'(i * 16'h0111), 0, 3'd0);
        end
        for (int s = 0; s < 8; s++) begin
            check($sformatf("mux_sel%0d", s), 32'(read_mux(3'(s))), 32'(16'hA000 + 16'(s * 16'h0111)));
        end
        check("sweep_err", 32'(err_a), 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            run_cycle(($urandom_range(0, 39) == 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                      16'($urandom), $urandom_range(0, 1), 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
